// File: rtl/sub_bytes_engine.sv
// AES SubBytes engine: substitutes all 16 state bytes, LANES per cycle, through registered S-box ROMs.
// Build option: define SUBBYTES_FWD_EN to add forward tables (in_inv selects); otherwise decrypt-only.
module sub_bytes_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy
);

    localparam int BEATS = 16 / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
        $error("sub_bytes_engine: LANES must be one of 1, 2, 4, 8, 16");
    end

    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                 state_q;
    logic [BW-1:0]          beat_q;
    logic [BW-1:0]          wr_beat_q;
    logic                   wr_en_q;
    logic [0:127]           blk_q;
    logic [0:127]           out_data_q;
    logic                   out_valid_q;
    logic                   busy_q;
    logic [LANES-1:0][7:0]  rom_q;
    logic [LANES-1:0][7:0]  rom_d;
    logic                   accept;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

`ifdef SUBBYTES_FWD_EN
    localparam logic [0:2047] FWD_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic inv_q;

    // The mode is captured once per block; in_inv is don't-care after accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inv_q <= 1'b0;
        end else if (accept) begin
            inv_q <= in_inv;
        end
    end

    // NOTE: combinational blocks assign every output on every path so no latch is inferred.
    always_comb begin
        rom_d = '0;
        for (int l = 0; l < LANES; l++) begin
            if (inv_q) begin
                rom_d[l] = INV_SBOX[{blk_q[8 * (int'(beat_q) * LANES + l) +: 8], 3'b000} +: 8];
            end else begin
                rom_d[l] = FWD_SBOX[{blk_q[8 * (int'(beat_q) * LANES + l) +: 8], 3'b000} +: 8];
            end
        end
    end
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;

    // NOTE: combinational blocks assign every output on every path so no latch is inferred.
    always_comb begin
        rom_d = '0;
        for (int l = 0; l < LANES; l++) begin
            rom_d[l] = INV_SBOX[{blk_q[8 * (int'(beat_q) * LANES + l) +: 8], 3'b000} +: 8];
        end
    end
`endif

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the data registers are reset too, since out_data has a defined reset value of zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            wr_beat_q   <= '0;
            wr_en_q     <= 1'b0;
            blk_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rom_q       <= '0;
        end else begin
            wr_en_q <= 1'b0;
            // ROM results registered last cycle land in their byte slots now.
            if (wr_en_q) begin
                for (int l = 0; l < LANES; l++) begin
                    out_data_q[8 * (int'(wr_beat_q) * LANES + l) +: 8] <= rom_q[l];
                end
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        blk_q   <= in_data;
                        beat_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    rom_q     <= rom_d;
                    wr_en_q   <= 1'b1;
                    wr_beat_q <= beat_q;
                    if (beat_q == LAST_BEAT) begin
                        state_q <= DRAIN;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                DRAIN: begin
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            blk_q   <= in_data;
                            beat_q  <= '0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine: one instance per legal LANES, checked against an S-box model built from GF(2^8) arithmetic.
module tb_sub_bytes_engine;

    localparam int N = 5;

    logic           clk;
    logic           reset_n;
    logic [0:127]   in_data;
    logic           in_inv;
    logic           out_ready;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   busy;
    logic [0:127]   out_data [N];

    int             checks;
    int             failures;
    logic [7:0]     fwd_tab [256];
    logic [7:0]     inv_tab [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        sub_bytes_engine #(.LANES(1 << g)) u_dut (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data),
            .in_inv   (in_inv),
            .out_valid(out_valid[g]),
            .out_ready(out_ready),
            .out_data (out_data[g]),
            .busy     (busy[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%032h expected=%032h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] w;
        w = {v, v} << n;
        return w[15:8];
    endfunction

    // Forward S-box = affine map of the multiplicative inverse; inverse table is its permutation inverse.
    task automatic build_tables();
        logic [7:0] x;
        logic [7:0] b;
        logic [7:0] s;
        for (int v = 0; v < 256; v++) begin
            x = 8'(v);
            b = 8'h00;
            if (x != 8'h00) begin
                b = 8'h01;
                for (int k = 0; k < 254; k++) b = gmul(b, x);
            end
            s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
            fwd_tab[v] = s;
            inv_tab[s] = x;
        end
    endtask

    function automatic logic [0:127] model(input logic [0:127] d, input logic inv);
        logic [0:127] r;
        logic         use_inv;
`ifdef SUBBYTES_FWD_EN
        use_inv = inv;
`else
        use_inv = 1'b1 | inv;
`endif
        for (int k = 0; k < 16; k++) begin
            r[8*k +: 8] = use_inv ? inv_tab[d[8*k +: 8]] : fwd_tab[d[8*k +: 8]];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a block to instance i, then waits for its result and checks latency and data.
    task automatic issue(input int i, input logic [0:127] d, input logic inv, input string tag);
        logic [0:127] exp;
        int           lat;
        exp         = model(d, inv);
        in_data     = d;
        in_inv      = inv;
        in_valid[i] = 1'b1;
        #1;
        check({tag, ".in_ready"}, 128'(in_ready[i]), 128'd1);
        tick();
        in_valid[i] = 1'b0;
        out_ready   = 1'b0;
        check({tag, ".busy"}, 128'(busy[i]), 128'd1);
        lat = 0;
        while (out_valid[i] !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, 128'(lat), 128'((16 >> i) + 1));
        check({tag, ".data"}, out_data[i], exp);
    endtask

    task automatic release_blk(input int i, input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".valid_drop"}, 128'(out_valid[i]), 128'd0);
        check({tag, ".idle_ready"}, 128'(in_ready[i]), 128'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:127] v;
        logic [0:127] r;
        logic [0:127] d;
        logic [0:127] exp;
        logic         inv;
        int           lat;

        checks    = 0;
        failures  = 0;
        in_valid  = '0;
        in_data   = '0;
        in_inv    = 1'b0;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        build_tables();

        repeat (2) tick();
        check("rst.out_valid", 128'(out_valid), 128'd0);
        check("rst.in_ready", 128'(in_ready), 128'h1f);
        check("rst.busy", 128'(busy), 128'd0);
        check("rst.out_data", out_data[2], 128'd0);
        reset_n = 1'b1;
        tick();

        // All-zero block through the inverse table.
        issue(2, 128'd0, 1'b1, "zero_inv");
        check("zero_inv.literal", out_data[2], {16{8'h52}});
        release_blk(2, "zero_inv");

        // FIPS-197 vector, then the result fed back through the inverse table.
        v = 128'h00112233445566778899aabbccddeeff;
        issue(2, v, 1'b0, "fips_fwd");
`ifdef SUBBYTES_FWD_EN
        check("fips_fwd.literal", out_data[2], 128'h638293c31bfc33f5c4eeacea4bc12816);
`endif
        release_blk(2, "fips_fwd");
        r = model(v, 1'b0);
        issue(2, r, 1'b1, "fips_back");
`ifdef SUBBYTES_FWD_EN
        check("fips_back.literal", out_data[2], v);
`endif
        release_blk(2, "fips_back");

        // Backpressure for 10 cycles, then a handshake coinciding with a new block.
        d   = {$urandom, $urandom, $urandom, $urandom};
        inv = 1'($urandom_range(0, 1));
        issue(2, d, inv, "bp");
        exp = model(d, inv);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp.hold_valid", 128'(out_valid[2]), 128'd1);
            check("bp.hold_data", out_data[2], exp);
            check("bp.hold_ready", 128'(in_ready[2]), 128'd0);
        end
        out_ready = 1'b1;
        d   = {$urandom, $urandom, $urandom, $urandom};
        inv = 1'($urandom_range(0, 1));
        issue(2, d, inv, "b2b");
        release_blk(2, "b2b");

        // in_valid and in_inv wiggled while busy must not disturb the block in flight.
        d           = {$urandom, $urandom, $urandom, $urandom};
        exp         = model(d, 1'b0);
        in_data     = d;
        in_inv      = 1'b0;
        in_valid[2] = 1'b1;
        #1;
        tick();
        in_data = ~d;
        in_inv  = 1'b1;
        lat     = 0;
        repeat (2) begin
            tick();
            lat++;
        end
        check("busy.in_ready", 128'(in_ready[2]), 128'd0);
        check("busy.busy", 128'(busy[2]), 128'd1);
        in_valid[2] = 1'b0;
        in_inv      = 1'b0;
        while (out_valid[2] !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        check("busy.latency", 128'(lat), 128'd5);
        check("busy.data", out_data[2], exp);
        release_blk(2, "busy");
        check("busy.not_accepted", 128'(busy[2]), 128'd0);

        // Reset while beat 2 of a LANES=2 block is in progress.
        in_data     = {$urandom, $urandom, $urandom, $urandom};
        in_valid[1] = 1'b1;
        #1;
        tick();
        in_valid[1] = 1'b0;
        repeat (2) tick();
        reset_n = 1'b0;
        #1;
        check("midrst.out_valid", 128'(out_valid[1]), 128'd0);
        check("midrst.in_ready", 128'(in_ready[1]), 128'd1);
        check("midrst.busy", 128'(busy[1]), 128'd0);
        reset_n = 1'b1;
        tick();
        d = {$urandom, $urandom, $urandom, $urandom};
        issue(1, d, 1'($urandom_range(0, 1)), "after_rst");
        release_blk(1, "after_rst");

        // Every table entry, both modes, on the single-beat instance.
        for (int m = 0; m < 2; m++) begin
            for (int blk = 0; blk < 16; blk++) begin
                for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(blk * 16 + k);
                issue(4, d, 1'(m), "table");
                release_blk(4, "table");
            end
        end

        // Random blocks across all lane widths.
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 4; k++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                issue(i, d, 1'($urandom_range(0, 1)), "sweep");
                release_blk(i, "sweep");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sub_bytes_engine.md
# sub_bytes_engine

Parametrised, handshaked AES byte-substitution engine. It takes a 128-bit AES state and applies the S-box (encrypt) or the inverse S-box (decrypt) to all 16 bytes, processing LANES bytes per cycle through registered S-box ROMs. It sits between the round-key/shift stages of the iterative encrypt/decrypt datapaths, and it trades area for throughput via LANES.

## Interface

Parameters:
- LANES, default 4: S-box lookups per cycle. Legal values are 1, 2, 4, 8, 16; any other value is an elaboration error.
- BEATS, default 16/LANES: derived and not overridable.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: in_data and in_inv are valid.
- in_ready, output, 1: engine can accept a block this cycle.
- in_data, input, [0:127]: state; byte k is bits [8k:8k+7], so byte 0 is the MSB.
- in_inv, input, 1: 1 selects the inverse S-box, 0 the forward S-box.
- out_valid, output, 1: out_data holds a completed block.
- out_ready, input, 1: downstream accepts out_data.
- out_data, output, [0:127]: substituted state, same byte order as in_data.
- busy, output, 1: high in RUN or DRAIN.

## Operation

- FSM states: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid, latch in_data and in_inv, clear beat counter, go to RUN.
- **RUN**
  - Each cycle, beat counter b (0..BEATS-1) issues ROM reads for bytes b*LANES .. b*LANES+LANES-1.
  - The ROM output registered one cycle later is written into the matching out_data bytes.
  - After beat BEATS-1 is issued, go to DRAIN.
- **DRAIN**
  - Lasts one cycle; writes the last beat's results.
  - Go to DONE.
- **DONE**
  - out_valid=1; out_data is stable until the handshake.
  - On out_ready, go to IDLE. If in_valid is also high that cycle, go directly to RUN with the new block.
  - in_ready = out_ready in DONE.
- in_ready is 0 in RUN and DRAIN. in_valid there is ignored and must be held by the source.
- The mode is latched at accept. in_inv changes mid-block have no effect.
- The beat counter is log2(BEATS) bits wide, minimum 1. It counts 0..BEATS-1 and never wraps mid-block.
- The S-box contents are the exact FIPS-197 forward and inverse tables.
- Bytes of out_data not yet written in a block retain the previous block's value. They are not observable, because out_valid=0.

## Timing

- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, beat counter=0.
- Reset mid-operation aborts the block immediately. No output is produced, and the first cycle after release is IDLE.
- Latency: if the accept edge is edge 0, out_valid rises after edge BEATS+1.
  - LANES=16 gives 2 cycles.
  - LANES=4 gives 5 cycles.
  - LANES=1 gives 17 cycles.
- Throughput with out_ready held high: one block per BEATS+2 cycles.
- Back-to-back: a DONE-state handshake coinciding with in_valid loses no cycle. The new block's beat 0 is issued on the following cycle.
- out_valid is held and out_data is unchanged while out_ready=0, for any duration.

## Configuration

- Macro: SUBBYTES_FWD_EN.
- Defined: the forward S-box ROM is instantiated per lane, and in_inv selects the table.
- Undefined:
  - Only the inverse S-box ROMs exist, and in_inv is ignored (treated as 1). This is the decrypt-only build.
  - All handshake and timing behaviour is identical.

## Test plan

- Reset, LANES=4, in_data=all 0x00, in_inv=1 → out_valid after edge 5, out_data=all 0x52; out_valid stays 0 before edge 5.
- in_inv=0, in_data=0x00112233445566778899AABBCCDDEEFF, SUBBYTES_FWD_EN defined → out_data=0x638293C31BFC33F5C4EEACEA4BC12816. Feeding that result back with in_inv=1 → original value.
- Backpressure: out_ready=0 for 10 cycles after completion → out_valid held, out_data stable, in_ready=0; set out_ready=1 with a new in_valid the same cycle → accepted with no idle cycle.
- in_valid pulsed while busy=1 → not accepted; in_inv toggled during RUN → result uses the latched mode.
- reset_n asserted at beat 2 of a LANES=2 block → out_valid=0, in_ready=1 immediately; a subsequent block completes correctly after 9 cycles.
- Sweep LANES over 1, 2, 4, 8, 16 with random blocks against a FIPS-197 model → latency BEATS+1 and bit-exact output. Repeat with SUBBYTES_FWD_EN undefined and in_inv=0 → inverse result produced.
